reflet_int_ctrl: RTL and testbench

REFLET_INT_CTRL -- requirements
Module: reflet_int_ctrl

---
 rtl/reflet_int_pkg.sv | 15 +
 rtl/reflet_int_prio_enc.sv | 28 ++
 rtl/reflet_int_ctrl.sv | 135 +++++++++++++
 tb/tb_reflet_int_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_int_pkg.sv
// reflet_int_pkg -- shared constants for the reflet interrupt controller.
//   reg_off_e : register offsets relative to base_addr
//               (ENABLE=0, PENDING=1, INSERVICE=2)
//   INT_NUM_W : width of the interrupt index reported to the CPU
package reflet_int_pkg;

  typedef enum logic [1:0] {
    REG_ENABLE    = 2'd0,
    REG_PENDING   = 2'd1,
    REG_INSERVICE = 2'd2
  } reg_off_e;

  localparam int unsigned INT_NUM_W = 3;

endpackage

// File: rtl/reflet_int_prio_enc.sv
// reflet_int_prio_enc -- combinational priority encoder.
// Reports the lowest set bit index of vec_i (bit 0 = highest priority).
//   vec_i : request vector, nb_src bits
//   idx_o : index of the lowest set bit (0 when none set)
//   vld_o : 1 when any bit of vec_i is set
module reflet_int_prio_enc
  import reflet_int_pkg::*;
#(
  parameter int unsigned nb_src = 4
) (
  input  logic [nb_src-1:0]    vec_i,
  output logic [INT_NUM_W-1:0] idx_o,
  output logic                 vld_o
);

  // Scan from the lowest priority upward so the last hit is the lowest index.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = int'(nb_src) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = INT_NUM_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reflet_int_ctrl.sv
// reflet_int_ctrl -- memory-mapped interrupt controller with edge-triggered
// pending bits, per-source enable and in-service tracking.
//   clk, reset           : clock, synchronous active-high reset
//   src                  : level interrupt lines, bit 0 highest priority
//   addr, data_in,
//   write_en, data_out   : register bus (ENABLE, PENDING W1C, INSERVICE RO)
//   int_req, int_num     : registered request and source index to the CPU
//   int_ack, int_eoi     : CPU acceptance and end-of-interrupt pulses
// Build option: define REFLET_INT_NESTING_EN to let a higher-priority source
// interrupt a lower-priority one in service; otherwise no request is issued
// while anything is in service.
module reflet_int_ctrl
  import reflet_int_pkg::*;
#(
  parameter int unsigned           wordsize  = 16,
  parameter logic [wordsize-1:0]   base_addr = wordsize'(16'hFF20),
  parameter int unsigned           nb_src    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [nb_src-1:0]    src,
  input  logic [wordsize-1:0]  addr,
  input  logic [wordsize-1:0]  data_in,
  input  logic                 write_en,
  output logic [wordsize-1:0]  data_out,
  output logic                 int_req,
  output logic [INT_NUM_W-1:0] int_num,
  input  logic                 int_ack,
  input  logic                 int_eoi
);

  logic [nb_src-1:0]    enable_q, enable_d;
  logic [nb_src-1:0]    pending_q, pending_d;
  logic [nb_src-1:0]    inservice_q, inservice_d;
  logic [nb_src-1:0]    src_prev_q;
  logic                 int_req_q, int_req_d;
  logic [INT_NUM_W-1:0] int_num_q, int_num_d;

  logic [nb_src-1:0]    rise;
  logic [nb_src-1:0]    allow;
  logic [nb_src-1:0]    cand_vec;
  logic [nb_src-1:0]    ack_mask;
  logic [nb_src-1:0]    eoi_mask;
  logic [nb_src-1:0]    w1c_mask;
  logic [INT_NUM_W-1:0] cand_idx, ins_idx;
  logic                 cand_vld, ins_vld;
  logic                 hit_enable, hit_pending, hit_inservice;
  logic                 ack_fire, eoi_fire;
  logic                 unused_data_in;

  assign unused_data_in = ^data_in;

  assign hit_enable    = (addr == base_addr + wordsize'(REG_ENABLE));
  assign hit_pending   = (addr == base_addr + wordsize'(REG_PENDING));
  assign hit_inservice = (addr == base_addr + wordsize'(REG_INSERVICE));

  assign rise     = src & ~src_prev_q;
  assign ack_fire = int_ack & int_req_q;
  assign eoi_fire = int_eoi & ins_vld;
  assign w1c_mask = (write_en && hit_pending) ? data_in[nb_src-1:0] : '0;

  // One-hot masks for the acked source, the eoi target and the priority
  // window left open by the current in-service set.
  always_comb begin
    allow    = '0;
    ack_mask = '0;
    eoi_mask = '0;
    for (int i = 0; i < int'(nb_src); i++) begin
`ifdef REFLET_INT_NESTING_EN
      allow[i] = !ins_vld || (INT_NUM_W'(i) < ins_idx);
`else
      allow[i] = (inservice_q == '0);
`endif
      ack_mask[i] = ack_fire && (int_num_q == INT_NUM_W'(i));
      eoi_mask[i] = eoi_fire && (ins_idx == INT_NUM_W'(i));
    end
  end

  assign cand_vec = pending_q & enable_q & allow;

  reflet_int_prio_enc #(.nb_src(nb_src)) u_cand_enc (
    .vec_i (cand_vec),
    .idx_o (cand_idx),
    .vld_o (cand_vld)
  );

  // Lowest set in-service bit: eoi target and nesting threshold.
  reflet_int_prio_enc #(.nb_src(nb_src)) u_ins_enc (
    .vec_i (inservice_q),
    .idx_o (ins_idx),
    .vld_o (ins_vld)
  );

  always_comb begin
    enable_d    = (write_en && hit_enable) ? data_in[nb_src-1:0] : enable_q;
    // A fresh edge is OR-ed in last so it beats an ack or W1C clear.
    pending_d   = (pending_q & ~w1c_mask & ~ack_mask) | rise;
    // eoi clears before ack sets, so a same-edge pair retires then accepts.
    inservice_d = (inservice_q & ~eoi_mask) | ack_mask;
    int_req_d   = cand_vld & ~ack_fire;
    int_num_d   = (cand_vld && !ack_fire) ? cand_idx : int_num_q;
  end

  always_ff @(posedge clk) begin
    src_prev_q <= src;
    if (reset) begin
      enable_q    <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      int_req_q   <= 1'b0;
      int_num_q   <= '0;
    end else begin
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      int_req_q   <= int_req_d;
      int_num_q   <= int_num_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (hit_enable) begin
      data_out[nb_src-1:0] = enable_q;
    end else if (hit_pending) begin
      data_out[nb_src-1:0] = pending_q;
    end else if (hit_inservice) begin
      data_out[nb_src-1:0] = inservice_q;
    end
  end

  assign int_req = int_req_q;
  assign int_num = int_num_q;

endmodule

// File: tb/tb_reflet_int_ctrl.sv
// Testbench for reflet_int_ctrl: directed vector table followed by a
// randomized run against a behavioural model of the controller rules.
module tb_reflet_int_ctrl;

  localparam int          WS   = 16;
  localparam logic [15:0] BASE = 16'hFF20;
  localparam int          NB   = 4;

`ifdef REFLET_INT_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] src;
  logic [WS-1:0] addr;
  logic [WS-1:0] data_in;
  logic          write_en;
  logic [WS-1:0] data_out;
  logic          int_req;
  logic [2:0]    int_num;
  logic          int_ack;
  logic          int_eoi;

  always #5 clk = ~clk;

  reflet_int_ctrl #(.wordsize(WS), .base_addr(BASE), .nb_src(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .src      (src),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .int_req  (int_req),
    .int_num  (int_num),
    .int_ack  (int_ack),
    .int_eoi  (int_eoi)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit [NB-1:0] s, input bit we,
                       input logic [WS-1:0] a, input logic [WS-1:0] d,
                       input bit ack, input bit eoi);
    reset    = r;
    src      = s;
    write_en = we;
    addr     = a;
    data_in  = d;
    int_ack  = ack;
    int_eoi  = eoi;
  endtask

  // ---------------- behavioural reference model ----------------
  int m_en[NB], m_pend[NB], m_ins[NB], m_prev[NB];
  int m_req, m_num;

  function automatic bit m_allowed(input int i);
    for (int j = 0; j < NB; j++) begin
      if (m_ins[j] != 0) begin
        if (!NEST) return 1'b0;
        if (j <= i) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic int m_cand();
    for (int i = 0; i < NB; i++)
      if (m_pend[i] != 0 && m_en[i] != 0 && m_allowed(i)) return i;
    return -1;
  endfunction

  task automatic m_step(input bit r, input bit [NB-1:0] s, input bit we,
                        input logic [WS-1:0] a, input logic [WS-1:0] d,
                        input bit ack, input bit eoi);
    int c;
    bit fire;
    if (r) begin
      for (int i = 0; i < NB; i++) begin
        m_en[i] = 0; m_pend[i] = 0; m_ins[i] = 0; m_prev[i] = int'(s[i]);
      end
      m_req = 0;
      m_num = 0;
      return;
    end
    c    = m_cand();
    fire = ack && (m_req != 0);
    if (we && a == BASE + 16'd1)
      for (int i = 0; i < NB; i++) if (d[i]) m_pend[i] = 0;
    if (fire) m_pend[m_num] = 0;
    for (int i = 0; i < NB; i++)
      if (s[i] && m_prev[i] == 0) m_pend[i] = 1;
    if (eoi) begin
      for (int i = 0; i < NB; i++)
        if (m_ins[i] != 0) begin m_ins[i] = 0; break; end
    end
    if (fire) m_ins[m_num] = 1;
    if (we && a == BASE)
      for (int i = 0; i < NB; i++) m_en[i] = int'(d[i]);
    m_req = (c >= 0 && !fire) ? 1 : 0;
    if (m_req != 0) m_num = c;
    for (int i = 0; i < NB; i++) m_prev[i] = int'(s[i]);
  endtask

  function automatic int m_read(input logic [WS-1:0] a);
    int v = 0;
    for (int i = 0; i < NB; i++) begin
      if (a == BASE)              v += m_en[i]   << i;
      else if (a == BASE + 16'd1) v += m_pend[i] << i;
      else if (a == BASE + 16'd2) v += m_ins[i]  << i;
    end
    return v;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit [NB-1:0] s;
    bit          we;
    int          off;
    bit [NB-1:0] din;
    bit          ack;
    bit          eoi;
    bit          exp_req;
    int          exp_num;
    int          exp_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, input bit [NB-1:0] s, input bit we,
                              input int off, input bit [NB-1:0] din, input bit ack,
                              input bit eoi, input bit exp_req, input int exp_num,
                              input int exp_rd);
    vec_t v;
    v.rst = rst; v.s = s; v.we = we; v.off = off; v.din = din;
    v.ack = ack; v.eoi = eoi; v.exp_req = exp_req; v.exp_num = exp_num;
    v.exp_rd = exp_rd;
    return v;
  endfunction

  initial begin
    logic [WS-1:0] a, d;
    bit [NB-1:0]   s_cur;
    bit            r, we, ack, eoi;

    drive(1'b1, '0, 1'b0, BASE, '0, 1'b0, 1'b0);

    // basic request on source 2
    tbl.push_back(mk(1, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'h4, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 4'h4, 0, 1, 4'h0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 4'h4, 0, 1, 4'h0, 0, 0, 1, 2, 4));
    tbl.push_back(mk(0, 4'h4, 0, 1, 4'h0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h4, 0, 2, 4'h0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 4'h4, 0, 2, 4'h0, 0, 1, 0, 0, 0));
    // priority: sources 3 and 1 together
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 0, 0, 0, 0, 15));
    tbl.push_back(mk(0, 4'hA, 0, 1, 4'h0, 0, 0, 0, 0, 10));
    tbl.push_back(mk(0, 4'hA, 0, 1, 4'h0, 0, 0, 1, 1, 10));
    tbl.push_back(mk(0, 4'hA, 0, 1, 4'h0, 1, 0, 0, 0, 8));
    tbl.push_back(mk(0, 4'hA, 0, 2, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'hA, 0, 1, 4'h0, 0, 0, 1, 3, 8));
    tbl.push_back(mk(0, 4'hA, 0, 2, 4'h0, 1, 0, 0, 0, 8));
    // nesting: source 0 rises while source 2 is in service
    tbl.push_back(mk(0, 4'h0, 0, 2, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h4, 0, 1, 4'h0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 4'h4, 0, 1, 4'h0, 0, 0, 1, 2, 4));
    tbl.push_back(mk(0, 4'h4, 0, 2, 4'h0, 1, 0, 0, 0, 4));
    tbl.push_back(mk(0, 4'h5, 0, 1, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h5, 0, 1, 4'h0, 0, 0, NEST, 0, 1));
    tbl.push_back(mk(0, 4'h5, 0, 2, 4'h0, 0, 1, NEST, 0, 0));
    tbl.push_back(mk(0, 4'h5, 0, 1, 4'h0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'h5, 0, 2, 4'h0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h5, 0, 2, 4'h0, 0, 1, 0, 0, 0));
    // W1C collides with a new edge; disable / re-enable
    tbl.push_back(mk(0, 4'h4, 0, 1, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h5, 1, 1, 4'h1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h5, 0, 1, 4'h0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 4'h5, 1, 0, 4'hE, 0, 0, 1, 0, 14));
    tbl.push_back(mk(0, 4'h5, 0, 1, 4'h0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h5, 1, 0, 4'hF, 0, 0, 0, 0, 15));
    tbl.push_back(mk(0, 4'h5, 0, 0, 4'h0, 0, 0, 1, 0, 15));
    // reset while source 1 is in service and its line stays high
    tbl.push_back(mk(0, 4'h5, 0, 2, 4'h0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 4'h4, 0, 2, 4'h0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'h6, 0, 1, 4'h0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 4'h6, 0, 1, 4'h0, 0, 0, 1, 1, 2));
    tbl.push_back(mk(0, 4'h6, 0, 2, 4'h0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 4'h6, 0, 2, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h6, 0, 1, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h6, 0, 0, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h6, 0, 3, 4'h0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'h6, 0, 8, 4'h0, 0, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].s, tbl[k].we, BASE + 16'(tbl[k].off),
            {12'h000, tbl[k].din}, tbl[k].ack, tbl[k].eoi);
      @(posedge clk);
      #1;
      check($sformatf("row%0d int_req", k), int'(int_req), int'(tbl[k].exp_req));
      if (tbl[k].exp_req)
        check($sformatf("row%0d int_num", k), int'(int_num), tbl[k].exp_num);
      check($sformatf("row%0d data_out", k), int'(data_out), tbl[k].exp_rd);
    end

    // ---------------- randomized run against the model ----------------
    s_cur = '0;
    drive(1'b1, s_cur, 1'b0, BASE, '0, 1'b0, 1'b0);
    @(posedge clk);
    m_step(1'b1, s_cur, 1'b0, BASE, '0, 1'b0, 1'b0);
    #1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int off;
      r = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) s_cur[$urandom_range(0, NB - 1)] ^= 1'b1;
      off = $urandom_range(0, 5);
      a   = (off < 4) ? BASE + 16'(off) : 16'($urandom_range(0, 255));
      d   = 16'($urandom);
      we  = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 2) == 0);
      eoi = ($urandom_range(0, 5) == 0);
      drive(r, s_cur, we, a, d, ack, eoi);
      @(posedge clk);
      m_step(r, s_cur, we, a, d, ack, eoi);
      #1;
      check($sformatf("rand%0d int_req", cyc), int'(int_req), m_req);
      if (m_req != 0)
        check($sformatf("rand%0d int_num", cyc), int'(int_num), m_num);
      check($sformatf("rand%0d data_out", cyc), int'(data_out), m_read(a));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
